uart_rx_frac: RTL
=================

Name: uart_rx_frac

Overview:
- Serial UART receiver for the AES_UART datapath. It converts the Rx pin into bytes.
- It uses an 8x-oversampled fractional baud generator driven by the same 12.4 BRR value the register block holds.
- Received bytes are presented on a ready/valid output to the RX FIFO / InvAES input stage.
- Framing errors and overruns are reported as single-cycle pulses for ISR flag capture.

Parameters:
- DATA_W, 8, data bits per frame (LSB first, no parity, 1 stop bit).
- OVS, 8, samples per bit period; fixed majority window at samples 3, 4, 5.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  reset; synchronous, active-low.
- prescale  input  16  BRR: [15:4] integer, [3:0] sixteenths of clocks per sample tick.
- enable  input  1  receiver enable (CR1.AUE & CR1.RE).
- Rx  input  1  asynchronous serial input.
- m_tdata  output  DATA_W  received byte.
- m_tvalid  output  1  byte valid; held until accepted.
- m_tready  input  1  downstream accept.
- busy  output  1  high whenever state != IDLE.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- **Reset (Rst=0 at posedge):**
  - state=IDLE, all counters 0.
  - Synchronizer flops = 1.
  - m_tdata=0, m_tvalid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame; no output is produced for it.
- **Synchronization:** Rx passes through 2 flops (reset value 1). Start is detected on the synchronized value when prev=1 and cur=0.
- **Tick generator:**
  - Runs only outside IDLE. It is cleared on start detection: clock count 0, 4-bit frac accumulator 0.
  - Each tick period is int clocks. When a tick is issued, frac_acc += prescale[3:0]; a carry out makes the next period int+1 clocks.
  - Example: BRR 0x06C8 gives periods alternating 108/109.
- **Sample counter:** 3 bits, counts ticks 0..7 within a bit. It shifts samples 3, 4, 5 into a vote register; majority is evaluated at sample 5.
- **States:**
  - IDLE:
    - If enable=1, prescale[15:4]!=0 and a falling edge is seen, go to START.
    - If prescale[15:4]==0 or enable=0, stay in IDLE and ignore Rx.
  - START: at the vote, majority=1 is a false start and returns to IDLE with no pulse. Otherwise go to DATA at the next bit boundary (sample 7 tick).
  - DATA:
    - Shift the vote result into bit[idx], LSB first; idx increments at each bit boundary.
    - After bit DATA_W-1, go to STOP.
  - STOP: at the vote, take the stop-bit action below, then return to IDLE immediately (no wait for the stop-bit end).
- **Stop-bit actions:**
  - Majority=1, m_tvalid=0 or m_tready=1: load m_tdata and set m_tvalid=1 on the next edge.
  - Majority=1, m_tvalid=1 and m_tready=0: pulse overrun; the old byte is retained and the new byte is dropped.
  - Majority=0: pulse frame_err; the byte is discarded and m_tvalid is unchanged.
- **Latency:** m_tvalid rises 1 clock after the stop-bit sample-5 tick.
- **Handshake:**
  - m_tvalid clears on the cycle after m_tvalid & m_tready.
  - If a new byte loads in the same cycle as the accept, m_tvalid stays 1 with the new data.
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
- **enable deasserted mid-frame:** return to IDLE on the next clock with no pulses; a pending m_tvalid is unaffected.
- **prescale changes** take effect from the next tick period. There is no requirement on frame integrity during a change.

Test Plan:
- BRR=0x06C8 at 100 MHz, enable=1, m_tready=1, inject 0x5A at 868 clk/bit -> exactly one m_tvalid with m_tdata=0x5A; frame_err=overrun=0; busy falls ~9.5 bit times after the start edge.
- Rx low for 300 clks then high -> START false-start, back to IDLE; no m_tvalid, no frame_err.
- Inject 0xC3 with the stop bit driven low -> one frame_err pulse; m_tvalid stays 0; a following 0x3C is received correctly.
- m_tready=0, inject 0x11 then 0x22 -> m_tdata=0x11 held valid; overrun pulses once at the second stop sample. Raising m_tready then yields 0x11 only.
- Rst=0 for one cycle during data bit 4 of 0xFF, then inject 0xA5 -> only 0xA5 is output; all outputs are 0 after the reset edge.
- BRR=0x0000 or enable=0, inject 0x77 -> busy stays 0; no output.

Source files
------------

// File: rtl/uart_rx_frac.sv
// UART receiver with an 8x-oversampled fractional (12.4) baud tick generator.
// Bytes leave on a ready/valid port; framing errors and overruns are one-cycle pulses.
module uart_rx_frac #(
   parameter int DATA_W = 8,
   parameter int OVS    = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [15:0]       prescale,
   input  logic              enable,
   input  logic              Rx,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int SAMP_W = $clog2(OVS);
   localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_reg, state_next;
   logic                rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic [11:0]         clk_cnt_reg, clk_cnt_next;
   logic [3:0]          frac_acc_reg, frac_acc_next;
   logic                extra_reg, extra_next;
   logic [SAMP_W-1:0]   samp_cnt_reg, samp_cnt_next;
   logic [1:0]          vote_reg, vote_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [DATA_W-1:0]   data_sh_reg, data_sh_next;
   logic [DATA_W-1:0]   m_tdata_reg, m_tdata_next;
   logic                m_tvalid_reg, m_tvalid_next;
   logic                frame_err_reg, frame_err_next;
   logic                overrun_reg, overrun_next;

   logic [12:0]         period;
   logic                tick, start_edge, can_run, majority, vote_pt, bit_end;

   // A carry out of the fraction accumulator stretches the following period by one clock
   assign period     = {1'b0, prescale[15:4]} + {12'd0, extra_reg};
   assign tick       = (state_reg != IDLE) && (({1'b0, clk_cnt_reg} + 13'd1) >= period);
   assign start_edge = rx_prev_reg & ~rx_sync_reg;
   assign can_run    = enable && (prescale[15:4] != 12'd0);
   assign majority   = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rx_sync_reg) |
                       (vote_reg[0] & rx_sync_reg);
   assign vote_pt    = tick && (samp_cnt_reg == SAMP_W'(5));
   assign bit_end    = tick && (samp_cnt_reg == SAMP_W'(OVS - 1));

   always_comb begin
      state_next     = state_reg;
      clk_cnt_next   = clk_cnt_reg;
      frac_acc_next  = frac_acc_reg;
      extra_next     = extra_reg;
      samp_cnt_next  = samp_cnt_reg;
      vote_next      = vote_reg;
      idx_next       = idx_reg;
      data_sh_next   = data_sh_reg;
      m_tdata_next   = m_tdata_reg;
      m_tvalid_next  = m_tvalid_reg;
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;

      if (m_tvalid_reg && m_tready)
         m_tvalid_next = 1'b0;

      if (tick) begin
         clk_cnt_next                = 12'd0;
         {extra_next, frac_acc_next} = {1'b0, frac_acc_reg} + {1'b0, prescale[3:0]};
         samp_cnt_next               = samp_cnt_reg + SAMP_W'(1);
         if (samp_cnt_reg == SAMP_W'(3) || samp_cnt_reg == SAMP_W'(4))
            vote_next = {vote_reg[0], rx_sync_reg};
      end else begin
         clk_cnt_next = clk_cnt_reg + 12'd1;
      end

      if (!enable && state_reg != IDLE) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               // Keep the tick generator parked so a start edge begins a clean period
               clk_cnt_next  = 12'd0;
               frac_acc_next = 4'd0;
               extra_next    = 1'b0;
               samp_cnt_next = '0;
               idx_next      = '0;
               if (can_run && start_edge)
                  state_next = START;
            end
            START: begin
               if (vote_pt && majority) begin
                  state_next = IDLE;
               end else if (bit_end) begin
                  state_next = DATA;
                  idx_next   = '0;
               end
            end
            DATA: begin
               if (vote_pt)
                  data_sh_next = {majority, data_sh_reg[DATA_W-1:1]};
               if (bit_end) begin
                  if (idx_reg == IDX_W'(DATA_W - 1))
                     state_next = STOP;
                  else
                     idx_next = idx_reg + IDX_W'(1);
               end
            end
            STOP: begin
               if (vote_pt) begin
                  state_next = IDLE;
                  if (!majority) begin
                     frame_err_next = 1'b1;
                  end else if (!m_tvalid_reg || m_tready) begin
                     m_tdata_next  = data_sh_reg;
                     m_tvalid_next = 1'b1;
                  end else begin
                     overrun_next = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_reg     <= IDLE;
         rx_meta_reg   <= 1'b1;
         rx_sync_reg   <= 1'b1;
         rx_prev_reg   <= 1'b1;
         clk_cnt_reg   <= 12'd0;
         frac_acc_reg  <= 4'd0;
         extra_reg     <= 1'b0;
         samp_cnt_reg  <= '0;
         vote_reg      <= 2'b00;
         idx_reg       <= '0;
         data_sh_reg   <= '0;
         m_tdata_reg   <= '0;
         m_tvalid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rx_meta_reg   <= Rx;
         rx_sync_reg   <= rx_meta_reg;
         rx_prev_reg   <= rx_sync_reg;
         clk_cnt_reg   <= clk_cnt_next;
         frac_acc_reg  <= frac_acc_next;
         extra_reg     <= extra_next;
         samp_cnt_reg  <= samp_cnt_next;
         vote_reg      <= vote_next;
         idx_reg       <= idx_next;
         data_sh_reg   <= data_sh_next;
         m_tdata_reg   <= m_tdata_next;
         m_tvalid_reg  <= m_tvalid_next;
         frame_err_reg <= frame_err_next;
         overrun_reg   <= overrun_next;
      end
   end

   assign m_tdata   = m_tdata_reg;
   assign m_tvalid  = m_tvalid_reg;
   assign busy      = (state_reg != IDLE);
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;

endmodule
